// File: rtl/cpu_pkg.sv
// Shared types for the fetch/execute sequencing logic of the 2-stage MIPS core.
//   fetch_state_t : sequencer state (BOOT after reset, RUN normally, SQUASH while EX holds a bubble)
//   redirect_t    : which source selected the next fetch address
//   ADDR_W_DEF    : default instruction-memory word-address width
package cpu_pkg;

    localparam int ADDR_W_DEF = 12;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        SQUASH
    } fetch_state_t;

    typedef enum logic [2:0] {
        SEQ,
        BR,
        J,
        JR,
        EXC
    } redirect_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-fetch-address selection.
// Ports:
//   ex_valid        in  instruction in EX is real; branch/jump inputs are ignored otherwise
//   exc_req         in  exception request (always wins, even on a bubble)
//   jump_reg_ex     in  jr/jalr in EX
//   jump_ex         in  j/jal in EX
//   branch_taken_ex in  taken conditional branch in EX
//   imm_ex          in  signed word offset of the branch
//   target_ex       in  word-address jump target
//   rs_data_ex      in  byte-address jr target
//   pc_fetch        in  current fetch address
//   pc_ex           in  word address of the instruction in EX
//   next_pc         out address to fetch next
//   redirect        out source that produced next_pc
module next_pc_calc
    import cpu_pkg::*;
#(
    parameter int               ADDR_W     = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = 'h100
) (
    input  logic              ex_valid,
    input  logic              exc_req,
    input  logic              jump_reg_ex,
    input  logic              jump_ex,
    input  logic              branch_taken_ex,
    input  logic [15:0]       imm_ex,
    input  logic [25:0]       target_ex,
    input  logic [31:0]       rs_data_ex,
    input  logic [ADDR_W-1:0] pc_fetch,
    input  logic [ADDR_W-1:0] pc_ex,
    output logic [ADDR_W-1:0] next_pc,
    output redirect_t         redirect
);

    logic [31:0]       br_full;
    logic [ADDR_W-1:0] seq_pc;
    logic              unused_bits;

    // Branch sum is formed at full width and truncated, so any ADDR_W wraps mod 2^ADDR_W.
    assign br_full = 32'(pc_ex) + 32'd1 + {{16{imm_ex[15]}}, imm_ex};
    assign seq_pc  = pc_fetch + ADDR_W'(1);

    // Bits above the memory's address range (and the jr byte offset) carry no meaning here.
    assign unused_bits = ^{br_full[31:ADDR_W], target_ex[25:ADDR_W],
                           rs_data_ex[31:ADDR_W+2], rs_data_ex[1:0]};

    always_comb begin
        next_pc  = seq_pc;
        redirect = SEQ;
        if (exc_req) begin
            next_pc  = EXC_VECTOR;
            redirect = EXC;
        end else if (ex_valid) begin
            if (jump_reg_ex) begin
                next_pc  = rs_data_ex[ADDR_W+1:2];
                redirect = JR;
            end else if (jump_ex) begin
                next_pc  = target_ex[ADDR_W-1:0];
                redirect = J;
            end else if (branch_taken_ex) begin
                next_pc  = br_full[ADDR_W-1:0];
                redirect = BR;
            end
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch/execute sequencer of the 2-stage MIPS core. Owns the fetch PC, tracks the word
// address and validity of the instruction in EX, applies redirects resolved in EX and
// inserts bubbles after exceptions (and after redirects when there is no delay slot).
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   stall_req        hold fetch and EX for another cycle
//   exc_req          redirect to EXC_VECTOR and squash (acts even while stalled)
//   branch_taken_EX, jump_EX, jump_reg_EX, imm_EX, target_EX, rs_data_EX
//                    control-transfer information for the instruction in EX
//   pc_fetch         instruction memory read address
//   load_EX          instruction_EX register captures imem[pc_fetch] this cycle
//   ex_valid         instruction in EX is real (0 = bubble)
//   pc_EX            word address of the instruction in EX
//   link_addr_EX     jal/jalr link byte address (pc_EX + 2 words)
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = 'h100,
    parameter bit                DELAY_SLOT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_req,
    input  logic              exc_req,
    input  logic              branch_taken_EX,
    input  logic              jump_EX,
    input  logic              jump_reg_EX,
    input  logic [15:0]       imm_EX,
    input  logic [25:0]       target_EX,
    input  logic [31:0]       rs_data_EX,
    output logic [ADDR_W-1:0] pc_fetch,
    output logic              load_EX,
    output logic              ex_valid,
    output logic [ADDR_W-1:0] pc_EX,
    output logic [31:0]       link_addr_EX
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_fetch_q, pc_fetch_d;
    logic [ADDR_W-1:0] pc_ex_q, pc_ex_d;
    logic              ex_valid_q, ex_valid_d;

    logic              adv;
    logic              squash;
    logic [ADDR_W-1:0] next_pc;
    redirect_t         redirect;
    logic [ADDR_W-1:0] link_pc;

    // An exception overrides a stall so it can never be blocked by a multi-cycle op.
    assign adv = !stall_req || exc_req;

    next_pc_calc #(
        .ADDR_W     (ADDR_W),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_pc_calc (
        .ex_valid        (ex_valid_q),
        .exc_req         (exc_req),
        .jump_reg_ex     (jump_reg_EX),
        .jump_ex         (jump_EX),
        .branch_taken_ex (branch_taken_EX),
        .imm_ex          (imm_EX),
        .target_ex       (target_EX),
        .rs_data_ex      (rs_data_EX),
        .pc_fetch        (pc_fetch_q),
        .pc_ex           (pc_ex_q),
        .next_pc         (next_pc),
        .redirect        (redirect)
    );

    // The word already fetched behind a redirect is discarded on exceptions always, and on
    // branches/jumps only when the core has no delay slot.
    assign squash = (redirect == EXC) || ((redirect != SEQ) && !DELAY_SLOT);

    always_comb begin
        state_d    = state_q;
        pc_fetch_d = pc_fetch_q;
        pc_ex_d    = pc_ex_q;
        ex_valid_d = ex_valid_q;
        if (adv) begin
            pc_fetch_d = next_pc;
            pc_ex_d    = pc_fetch_q;
            case (state_q)
                RUN: begin
                    state_d    = squash ? SQUASH : RUN;
                    ex_valid_d = !squash;
                end
                // EX holds no real instruction here, so only an exception can redirect.
                BOOT, SQUASH: begin
                    state_d    = exc_req ? SQUASH : RUN;
                    ex_valid_d = !exc_req;
                end
                default: begin
                    state_d    = BOOT;
                    ex_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_fetch_q <= RESET_PC;
            pc_ex_q    <= '0;
            ex_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_fetch_q <= pc_fetch_d;
            pc_ex_q    <= pc_ex_d;
            ex_valid_q <= ex_valid_d;
        end
    end

    assign link_pc      = pc_ex_q + ADDR_W'(2);
    assign link_addr_EX = {{(30-ADDR_W){1'b0}}, link_pc, 2'b00};

    assign pc_fetch = pc_fetch_q;
    assign pc_EX    = pc_ex_q;
    assign ex_valid = ex_valid_q;
    assign load_EX  = adv && !rst;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: two instances (delay slot on / off) share one
// stimulus stream and are compared every cycle against a behavioural model, with
// directed scenarios followed by randomized traffic.
module tb_fetch_ctrl;

    localparam int AW   = 12;
    localparam int MASK = 32'hFFF;
    localparam int EXCV = 32'h100;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_req, exc_req, br, jmp, jr;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] rs;

    logic [AW-1:0] pf   [2];
    logic [AW-1:0] pcex [2];
    logic          ld   [2];
    logic          vld  [2];
    logic [31:0]   link [2];

    int m_pc   [2];
    int m_pcex [2];
    int m_vld  [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.ADDR_W(AW), .DELAY_SLOT(1'b1)) u_ds1 (
        .clk(clk), .rst(rst), .stall_req(stall_req), .exc_req(exc_req),
        .branch_taken_EX(br), .jump_EX(jmp), .jump_reg_EX(jr),
        .imm_EX(imm), .target_EX(tgt), .rs_data_EX(rs),
        .pc_fetch(pf[0]), .load_EX(ld[0]), .ex_valid(vld[0]),
        .pc_EX(pcex[0]), .link_addr_EX(link[0])
    );

    fetch_ctrl #(.ADDR_W(AW), .DELAY_SLOT(1'b0)) u_ds0 (
        .clk(clk), .rst(rst), .stall_req(stall_req), .exc_req(exc_req),
        .branch_taken_EX(br), .jump_EX(jmp), .jump_reg_EX(jr),
        .imm_EX(imm), .target_EX(tgt), .rs_data_EX(rs),
        .pc_fetch(pf[1]), .load_EX(ld[1]), .ex_valid(vld[1]),
        .pc_EX(pcex[1]), .link_addr_EX(link[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Architectural rules: priority exc > jr > j > branch > sequential, control ignored on
    // bubbles, exception always kills the following word, redirects kill it only without
    // a delay slot; nothing moves while stalled unless an exception arrives.
    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            bit ds;
            int nxt;
            bit ctl;
            ds = (i == 0);
            if (rst) begin
                m_pc[i]   = 0;
                m_pcex[i] = 0;
                m_vld[i]  = 0;
            end else if (!stall_req || exc_req) begin
                ctl = (m_vld[i] != 0) && (jr || jmp || br);
                if (exc_req)                  nxt = EXCV;
                else if (m_vld[i] != 0 && jr)  nxt = int'(rs >> 2) & MASK;
                else if (m_vld[i] != 0 && jmp) nxt = int'(tgt) & MASK;
                else if (m_vld[i] != 0 && br)  nxt = (m_pcex[i] + 1 + int'($signed(imm))) & MASK;
                else                          nxt = (m_pc[i] + 1) & MASK;
                m_vld[i]  = (exc_req || (ctl && !ds)) ? 0 : 1;
                m_pcex[i] = m_pc[i];
                m_pc[i]   = nxt;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            string s;
            int exp_ld;
            s = (i == 0) ? "ds1" : "ds0";
            exp_ld = (!rst && (!stall_req || exc_req)) ? 1 : 0;
            chk({s, " pc_fetch"}, 32'(pf[i]), m_pc[i]);
            chk({s, " pc_EX"}, 32'(pcex[i]), m_pcex[i]);
            chk({s, " ex_valid"}, 32'(vld[i]), m_vld[i]);
            chk({s, " load_EX"}, 32'(ld[i]), exp_ld);
            chk({s, " link_addr"}, link[i], ((m_pcex[i] + 2) & MASK) << 2);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic clear_inputs();
        stall_req = 1'b0; exc_req = 1'b0; br = 1'b0; jmp = 1'b0; jr = 1'b0;
        imm = '0; tgt = '0; rs = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst pc_fetch", 32'(pf[0]), 0);
        chk("rst ex_valid", 32'(vld[0]), 0);
    endtask

    task automatic run_to(input int n);
        for (int k = 0; k < 64 && m_pcex[0] != n; k++) step();
        chk("reach pc_EX", 32'(pcex[0]), n);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = 0; m_pcex[i] = 0; m_vld[i] = 0;
        end

        // Reset then free-run
        do_reset();
        step();
        chk("boot pc_fetch", 32'(pf[0]), 1);
        chk("boot ex_valid", 32'(vld[0]), 1);
        step();
        step();
        chk("run pc_fetch", 32'(pf[0]), 3);
        chk("run pc_EX", 32'(pcex[0]), 2);

        // Branch back by 3 from word 5
        run_to(5);
        br = 1'b1; imm = 16'hFFFD;
        step();
        clear_inputs();
        chk("br ds1 pc_fetch", 32'(pf[0]), 3);
        chk("br ds1 slot valid", 32'(vld[0]), 1);
        chk("br ds0 pc_EX", 32'(pcex[1]), 6);
        chk("br ds0 slot squashed", 32'(vld[1]), 0);
        step();
        chk("br ds0 target in EX", 32'(pcex[1]), 3);
        chk("br ds0 target valid", 32'(vld[1]), 1);

        // jr from word 9
        do_reset();
        run_to(9);
        chk("jr link_addr", link[0], 32'h2C);
        jr = 1'b1; rs = 32'h40;
        step();
        clear_inputs();
        chk("jr pc_fetch", 32'(pf[0]), 32'h10);

        // Taken branch held by a 3-cycle stall, then exception during a stall
        do_reset();
        run_to(4);
        br = 1'b1; imm = 16'd2; stall_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall pc_fetch", 32'(pf[0]), 5);
            chk("stall pc_EX", 32'(pcex[0]), 4);
        end
        stall_req = 1'b0;
        step();
        chk("stall release target", 32'(pf[0]), 7);
        br = 1'b0; stall_req = 1'b1; exc_req = 1'b1;
        step();
        clear_inputs();
        chk("exc pc_fetch", 32'(pf[0]), EXCV);
        chk("exc ex_valid", 32'(vld[0]), 0);

        // Sequential wrap from the top of the address space
        do_reset();
        run_to(2);
        jmp = 1'b1; tgt = 26'hFFF;
        step();
        clear_inputs();
        chk("wrap top", 32'(pf[0]), 32'hFFF);
        step();
        chk("wrap ds1", 32'(pf[0]), 0);
        chk("wrap ds0", 32'(pf[1]), 0);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            rst       = ($urandom_range(63) == 0);
            stall_req = ($urandom_range(3) == 0);
            exc_req   = ($urandom_range(15) == 0);
            br        = ($urandom_range(3) == 0);
            jmp       = ($urandom_range(7) == 0);
            jr        = ($urandom_range(7) == 0);
            imm       = 16'($urandom);
            tgt       = 26'($urandom);
            rs        = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
